// File: rtl/qie_power_sequencer.sv
// QIE card power sequencer for the ngCCM emulator.
// Delays penable after reset, waits for a filtered pgood with a timeout, then
// releases the two peltier enables one stagger apart. A pgood loss or timeout
// starts a backoff and counts a retry; too many retries latch a fault until
// clear_fault. With mode=0 the card pins follow the raw *_in pins instead.
module qie_power_sequencer #(
    parameter int CNT_W         = 19,
    parameter int TURNON_DELAY  = 400000,
    parameter int PGOOD_TIMEOUT = 200000,
    parameter int PGOOD_FILTER  = 16,
    parameter int PELT_STAGGER  = 1000,
    parameter int RETRY_BACKOFF = 100000,
    parameter int MAX_RETRY     = 3
) (
    input  logic       delay_clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       clear_fault,
    input  logic       penable_in,
    input  logic       peltEnable1_in,
    input  logic       peltEnable2_in,
    input  logic       pgood_in,
    output logic       penable_out,
    output logic       peltEnable1_out,
    output logic       peltEnable2_out,
    output logic       pgood_out,
    output logic       fault,
    output logic [2:0] seq_state,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        S_DELAY   = 3'd0,
        S_RAMP    = 3'd1,
        S_PELT1   = 3'd2,
        S_RUN     = 3'd3,
        S_BACKOFF = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    // The filter counter only has to reach PGOOD_FILTER-1.
    localparam int FLT_W = (PGOOD_FILTER > 1) ? $clog2(PGOOD_FILTER) : 1;

    localparam logic [FLT_W-1:0] L_FLT_LAST     = FLT_W'(PGOOD_FILTER - 1);
    localparam logic [CNT_W-1:0] L_TURNON_LAST  = CNT_W'(TURNON_DELAY - 1);
    localparam logic [CNT_W-1:0] L_TIMEOUT_LAST = CNT_W'(PGOOD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] L_STAGGER_LAST = CNT_W'(PELT_STAGGER - 1);
    localparam logic [CNT_W-1:0] L_BACKOFF_LAST = CNT_W'(RETRY_BACKOFF - 1);
    localparam logic [3:0]       L_MAX_RETRY    = 4'(MAX_RETRY);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_retry;
    logic [3:0]         w_next_retry;
    logic [3:0]         w_retry_inc;
    logic               w_counting;
    logic               r_pg_meta;
    logic               r_pg_sync;
    logic [FLT_W-1:0]   r_flt_cnt;
    logic               r_pgood_ok;
    logic               r_penable_seq;
    logic               r_pelt1_seq;
    logic               r_pelt2_seq;
    logic               r_fault;

    // Two-flop synchroniser for the asynchronous card pgood.
    always_ff @(posedge delay_clk) begin
        if (reset) begin
            r_pg_meta <= 1'b0;
            r_pg_sync <= 1'b0;
        end else begin
            r_pg_meta <= pgood_in;
            r_pg_sync <= r_pg_meta;
        end
    end

    // Debounce: pgood_ok flips only after PGOOD_FILTER consecutive opposite samples.
    always_ff @(posedge delay_clk) begin
        if (reset) begin
            r_flt_cnt  <= '0;
            r_pgood_ok <= 1'b0;
        end else if (r_pg_sync == r_pgood_ok) begin
            r_flt_cnt  <= '0;
            r_pgood_ok <= r_pgood_ok;
        end else if (r_flt_cnt == L_FLT_LAST) begin
            r_flt_cnt  <= '0;
            r_pgood_ok <= r_pg_sync;
        end else begin
            r_flt_cnt  <= r_flt_cnt + FLT_W'(1);
            r_pgood_ok <= r_pgood_ok;
        end
    end

    // Saturating increment used when an attempt fails.
    assign w_retry_inc = (r_retry >= L_MAX_RETRY) ? r_retry : (r_retry + 4'd1);

    // Only the timed states advance the counter, so RUN/FAULT can never wrap it.
    assign w_counting = (r_state == S_DELAY) || (r_state == S_RAMP) ||
                        (r_state == S_PELT1) || (r_state == S_BACKOFF);

    // Next-state and retry bookkeeping; pgood loss outranks stagger completion,
    // qualified pgood outranks the ramp timeout.
    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry;
        case (r_state)
            S_DELAY: begin
                if (r_cnt == L_TURNON_LAST) w_next_state = S_RAMP;
                else                        w_next_state = S_DELAY;
            end
            S_RAMP: begin
                if (r_pgood_ok) begin
                    w_next_state = S_PELT1;
                end else if (r_cnt == L_TIMEOUT_LAST) begin
                    w_next_retry = w_retry_inc;
                    w_next_state = (w_retry_inc == L_MAX_RETRY) ? S_FAULT : S_BACKOFF;
                end else begin
                    w_next_state = S_RAMP;
                end
            end
            S_PELT1: begin
                if (!r_pgood_ok) begin
                    w_next_retry = w_retry_inc;
                    w_next_state = (w_retry_inc == L_MAX_RETRY) ? S_FAULT : S_BACKOFF;
                end else if (r_cnt == L_STAGGER_LAST) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_PELT1;
                end
            end
            S_RUN: begin
                if (!r_pgood_ok) begin
                    w_next_retry = w_retry_inc;
                    w_next_state = (w_retry_inc == L_MAX_RETRY) ? S_FAULT : S_BACKOFF;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_BACKOFF: begin
                if (r_cnt == L_BACKOFF_LAST) w_next_state = S_DELAY;
                else                         w_next_state = S_BACKOFF;
            end
            S_FAULT: begin
                if (clear_fault) begin
                    w_next_state = S_DELAY;
                    w_next_retry = 4'd0;
                end else begin
                    w_next_state = S_FAULT;
                end
            end
            default: begin
                w_next_state = S_DELAY;
            end
        endcase
    end

    // State, retry count and the registered enables/fault decoded from the next state.
    always_ff @(posedge delay_clk) begin
        if (reset) begin
            r_state       <= S_DELAY;
            r_retry       <= 4'd0;
            r_penable_seq <= 1'b0;
            r_pelt1_seq   <= 1'b0;
            r_pelt2_seq   <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_retry       <= w_next_retry;
            r_penable_seq <= (w_next_state == S_RAMP) || (w_next_state == S_PELT1) ||
                             (w_next_state == S_RUN);
            r_pelt1_seq   <= (w_next_state == S_PELT1) || (w_next_state == S_RUN);
            r_pelt2_seq   <= (w_next_state == S_RUN);
            r_fault       <= (w_next_state == S_FAULT);
        end
    end

    // Shared delay/timeout counter, restarted on every state change.
    always_ff @(posedge delay_clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if (w_counting) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Output mux on registered sequencer bits so a mode change is seen the same cycle.
    assign penable_out     = mode ? r_penable_seq : penable_in;
    assign peltEnable1_out = mode ? (r_pelt1_seq & peltEnable1_in) : peltEnable1_in;
    assign peltEnable2_out = mode ? (r_pelt2_seq & peltEnable2_in) : peltEnable2_in;
    assign pgood_out       = r_pgood_ok;
    assign fault           = r_fault;
    assign seq_state       = r_state;
    assign retry_count     = r_retry;

endmodule

// File: tb/tb_qie_power_sequencer.sv
// Self-checking bench for qie_power_sequencer with small timing parameters.
// A behavioural model (sample history queue for pgood, phase/elapsed-time
// sequencing) predicts every output each cycle; directed scenarios are
// followed by a randomized soak.
module tb_qie_power_sequencer;

    localparam int TURNON    = 10;
    localparam int TIMEOUT   = 20;
    localparam int FILTER    = 3;
    localparam int STAGGER   = 5;
    localparam int BACKOFF   = 8;
    localparam int MAXR      = 2;

    logic       delay_clk = 1'b0;
    logic       reset, mode, clear_fault, penable_in;
    logic       peltEnable1_in, peltEnable2_in, pgood_in;
    logic       penable_out, peltEnable1_out, peltEnable2_out, pgood_out, fault;
    logic [2:0] seq_state;
    logic [3:0] retry_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_phase;
    int m_time;
    int m_retry;
    bit m_ok;
    bit m_pipe[$];
    bit m_hist[$];

    qie_power_sequencer #(
        .CNT_W(19), .TURNON_DELAY(TURNON), .PGOOD_TIMEOUT(TIMEOUT),
        .PGOOD_FILTER(FILTER), .PELT_STAGGER(STAGGER),
        .RETRY_BACKOFF(BACKOFF), .MAX_RETRY(MAXR)
    ) dut (
        .delay_clk(delay_clk), .reset(reset), .mode(mode), .clear_fault(clear_fault),
        .penable_in(penable_in), .peltEnable1_in(peltEnable1_in),
        .peltEnable2_in(peltEnable2_in), .pgood_in(pgood_in),
        .penable_out(penable_out), .peltEnable1_out(peltEnable1_out),
        .peltEnable2_out(peltEnable2_out), .pgood_out(pgood_out), .fault(fault),
        .seq_state(seq_state), .retry_count(retry_count)
    );

    always #5 delay_clk = ~delay_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_time  = 0;
        m_retry = 0;
        m_ok    = 1'b0;
        m_pipe  = {1'b0, 1'b0};
        m_hist  = {};
    endtask

    // One rising edge of the reference: sequencing decisions use the pgood
    // qualification as it stood before the edge.
    task automatic model_edge();
        int  nxt;
        bit  failed;
        bit  s;
        bit  all_opp;
        if (reset) begin
            model_reset();
            return;
        end
        nxt = m_phase;
        failed = 1'b0;
        case (m_phase)
            0: if (m_time + 1 >= TURNON) nxt = 1;
            1: if (m_ok) nxt = 2; else if (m_time + 1 >= TIMEOUT) failed = 1'b1;
            2: if (!m_ok) failed = 1'b1; else if (m_time + 1 >= STAGGER) nxt = 3;
            3: if (!m_ok) failed = 1'b1;
            4: if (m_time + 1 >= BACKOFF) nxt = 0;
            5: if (clear_fault) begin nxt = 0; m_retry = 0; end
            default: nxt = 0;
        endcase
        if (failed) begin
            m_retry = (m_retry < MAXR) ? m_retry + 1 : MAXR;
            nxt = (m_retry == MAXR) ? 5 : 4;
        end
        m_time  = (nxt != m_phase) ? 0 : m_time + 1;
        m_phase = nxt;
        // pgood: sample that reaches the filter was on the pin two edges ago
        s = m_pipe.pop_front();
        m_pipe.push_back(pgood_in);
        m_hist.push_back(s);
        if (m_hist.size() > FILTER) void'(m_hist.pop_front());
        if (m_hist.size() == FILTER) begin
            all_opp = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] == m_ok) all_opp = 1'b0;
            if (all_opp) m_ok = !m_ok;
        end
    endtask

    task automatic check_outputs();
        bit on_pen, on_p1, on_p2;
        on_pen = (m_phase >= 1) && (m_phase <= 3);
        on_p1  = (m_phase == 2) || (m_phase == 3);
        on_p2  = (m_phase == 3);
        chk("penable_out", {7'd0, penable_out}, {7'd0, mode ? on_pen : penable_in});
        chk("pelt1_out", {7'd0, peltEnable1_out},
            {7'd0, mode ? (on_p1 & peltEnable1_in) : peltEnable1_in});
        chk("pelt2_out", {7'd0, peltEnable2_out},
            {7'd0, mode ? (on_p2 & peltEnable2_in) : peltEnable2_in});
        chk("pgood_out", {7'd0, pgood_out}, {7'd0, m_ok});
        chk("fault", {7'd0, fault}, {7'd0, m_phase == 5});
        chk("seq_state", {5'd0, seq_state}, 8'(m_phase));
        chk("retry_count", {4'd0, retry_count}, 8'(m_retry));
    endtask

    // Called just after a falling edge with new inputs applied.
    task automatic step();
        #1;
        check_outputs();
        @(posedge delay_clk);
        model_edge();
        @(negedge delay_clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int hold;
        reset = 1'b1; mode = 1'b1; clear_fault = 1'b0; penable_in = 1'b0;
        peltEnable1_in = 1'b1; peltEnable2_in = 1'b1; pgood_in = 1'b1;
        model_reset();
        repeat (2) @(posedge delay_clk);
        @(negedge delay_clk);

        // 1: normal power-up with pgood present
        do_reset();
        for (int c = 0; c < 40; c++) step();

        // 2: pgood absent -> timeout, retry, fault, clear
        pgood_in = 1'b0;
        for (int c = 0; c < 110; c++) step();
        clear_fault = 1'b1; step(); clear_fault = 1'b0;
        for (int c = 0; c < 5; c++) step();

        // 3: glitches in RUN
        pgood_in = 1'b1;
        for (int c = 0; c < 40; c++) step();
        pgood_in = 1'b0; step(); step(); pgood_in = 1'b1;
        for (int c = 0; c < 10; c++) step();
        pgood_in = 1'b0; repeat (4) step(); pgood_in = 1'b1;
        for (int c = 0; c < 45; c++) step();

        // 5: reset while running
        reset = 1'b1; step(); reset = 1'b0;
        for (int c = 0; c < 3; c++) step();

        // 4: raw passthrough, then switch to sequencer mid-delay
        do_reset();
        mode = 1'b0;
        for (int c = 0; c < 6; c++) begin
            penable_in = 1'($urandom); peltEnable1_in = 1'($urandom);
            peltEnable2_in = 1'($urandom);
            step();
        end
        penable_in = 1'b1; peltEnable1_in = 1'b1; peltEnable2_in = 1'b1;
        mode = 1'b1;
        for (int c = 0; c < 30; c++) step();

        // 6: pgood qualifying around the ramp timeout edge
        for (int r = 18; r <= 30; r++) begin
            pgood_in = 1'b0;
            do_reset();
            for (int c = 0; c < 45; c++) begin
                if (c == r) pgood_in = 1'b1;
                step();
            end
        end

        // randomized soak
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                pgood_in = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
                hold = $urandom_range(1, 40);
            end
            hold--;
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            if ($urandom_range(0, 19) == 0) peltEnable1_in = 1'($urandom);
            if ($urandom_range(0, 19) == 0) peltEnable2_in = 1'($urandom);
            penable_in  = 1'($urandom);
            clear_fault = ($urandom_range(0, 9) == 0);
            reset       = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0; clear_fault = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
